// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO pad bank: pin type/direction encodings and
// default synchroniser depth and debounce counter width.
package gpio_pkg;

  localparam logic GPIO_TYPE_PP = 1'b0;
  localparam logic GPIO_TYPE_OD = 1'b1;
  localparam logic GPIO_DIR_IN  = 1'b0;
  localparam logic GPIO_DIR_OUT = 1'b1;

  localparam int GPIO_SYNC_STAGES_DEF = 2;
  localparam int GPIO_DEB_W_DEF       = 8;

endpackage

// File: rtl/gpio_pin_filter.sv
// One pin's input path: synchroniser, optional debounce, edge detect and sticky
// pending bit. Debounce counter exists only with GPIO_PAD_BANK_DEBOUNCE_EN.
module gpio_pin_filter
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEF,
  parameter int DEB_W       = GPIO_DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad,
  input  logic             dir,
  input  logic             deb_en,
  input  logic [DEB_W-1:0] deb_thr,
  input  logic             irq_rise_en,
  input  logic             irq_fall_en,
  input  logic             irq_clr,
  output logic             filt,
  output logic             pend
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   stable;
  logic                   prev;
  logic                   is_in;
  logic                   rise;
  logic                   fall;
  logic                   pend_set;

  assign is_in = (dir == GPIO_DIR_IN);
  assign sync  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  end

`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] CNT_ONE = DEB_W'(1);

  logic [DEB_W-1:0] cnt;
  logic             deb_on;

  assign deb_on = deb_en && (deb_thr != '0) && is_in;

  // A return to the stable level clears the count, so short glitches never land.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (!deb_on) begin
      stable <= sync;
      cnt    <= '0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt == deb_thr - CNT_ONE) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end
`else
  logic unused_deb;
  assign unused_deb = ^{deb_en, deb_thr};

  always_ff @(posedge clk) begin
    if (rst) stable <= 1'b0;
    else     stable <= sync;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= stable;
  end

  assign rise     = stable & ~prev & is_in;
  assign fall     = ~stable & prev & is_in;
  assign pend_set = (rise & irq_rise_en) | (fall & irq_fall_en);

  always_ff @(posedge clk) begin
    if (rst)           pend <= 1'b0;
    else if (pend_set) pend <= 1'b1;
    else if (irq_clr)  pend <= 1'b0;
  end

  assign filt = stable & is_in;

endmodule

// File: rtl/gpio_pad_bank.sv
// Multi-pin GPIO pad bank: per-pin push-pull/open-drain tri-state drive, filtered
// inputs and interrupt. Define GPIO_PAD_BANK_DEBOUNCE_EN to build the debounce counters.
module gpio_pad_bank
  import gpio_pkg::*;
#(
  parameter int NUM_PINS    = 16,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEF,
  parameter int DEB_W       = GPIO_DEB_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] r_type,
  input  logic [NUM_PINS-1:0] r_dir,
  input  logic [NUM_PINS-1:0] gpio_out,
  input  logic [NUM_PINS-1:0] r_deb_en,
  input  logic [DEB_W-1:0]    r_deb_thr,
  input  logic [NUM_PINS-1:0] r_irq_en,
  input  logic [NUM_PINS-1:0] r_irq_rise,
  input  logic [NUM_PINS-1:0] r_irq_fall,
  input  logic [NUM_PINS-1:0] irq_clr,
  output logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] irq_pend,
  output logic                irq,
  inout  wire  [NUM_PINS-1:0] gpio
);

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    logic drive_en;
    logic drive_val;

    // Open-drain pins only ever pull low; a high output releases the pad.
    assign drive_en  = (r_dir[i] == GPIO_DIR_OUT) &&
                       ((r_type[i] == GPIO_TYPE_PP) || (gpio_out[i] == 1'b0));
    assign drive_val = (r_type[i] == GPIO_TYPE_OD) ? 1'b0 : gpio_out[i];
    assign gpio[i]   = drive_en ? drive_val : 1'bz;

    gpio_pin_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_W      (DEB_W)
    ) u_filter (
      .clk        (clk),
      .rst        (rst),
      .pad        (gpio[i]),
      .dir        (r_dir[i]),
      .deb_en     (r_deb_en[i]),
      .deb_thr    (r_deb_thr),
      .irq_rise_en(r_irq_rise[i]),
      .irq_fall_en(r_irq_fall[i]),
      .irq_clr    (irq_clr[i]),
      .filt       (gpio_in[i]),
      .pend       (irq_pend[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(irq_pend & r_irq_en);
  end

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed bench for gpio_pad_bank with 4 pins and a 2-stage synchroniser.
// Expected debounce behaviour follows whether GPIO_PAD_BANK_DEBOUNCE_EN is defined.
module tb_gpio_pad_bank;

  localparam int NP   = 4;
  localparam int SYNC = 2;
  localparam int DW   = 8;
`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
  localparam bit DEB_BUILT = 1'b1;
`else
  localparam bit DEB_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] r_type, r_dir, gpio_out, r_deb_en;
  logic [DW-1:0] r_deb_thr;
  logic [NP-1:0] r_irq_en, r_irq_rise, r_irq_fall, irq_clr;
  logic [NP-1:0] gpio_in, irq_pend;
  logic          irq;
  wire  [NP-1:0] gpio;
  logic [NP-1:0] tb_en, tb_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NP; i++) begin : g_pad
    assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end
  pullup pu0 (gpio[0]);

  gpio_pad_bank #(.NUM_PINS(NP), .SYNC_STAGES(SYNC), .DEB_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .r_type    (r_type),
    .r_dir     (r_dir),
    .gpio_out  (gpio_out),
    .r_deb_en  (r_deb_en),
    .r_deb_thr (r_deb_thr),
    .r_irq_en  (r_irq_en),
    .r_irq_rise(r_irq_rise),
    .r_irq_fall(r_irq_fall),
    .irq_clr   (irq_clr),
    .gpio_in   (gpio_in),
    .irq_pend  (irq_pend),
    .irq       (irq),
    .gpio      (gpio)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_checks++;
    if (gpio_in !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_gpio_in: got %b expected 0000", gpio_in);
    end
    n_checks++;
    if (irq_pend !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_pend: got %b expected 0000", irq_pend);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_drive_modes();
    logic [2:0] exp_pad;
    logic [2:0] types;
    logic [2:0] outs;
    exp_pad = 3'b011;
    types   = 3'b110;
    outs    = 3'b011;
    tb_en[0] = 1'b0;
    r_dir[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r_type[0]   = types[k];
      gpio_out[0] = outs[k];
      step(4);
      n_checks++;
      if (gpio[0] !== exp_pad[k]) begin
        n_fail++; $display("[TB] FAIL drive_pin0_case%0d: got %b expected %b", k, gpio[0], exp_pad[k]);
      end
      n_checks++;
      if (gpio_in[0] !== 1'b0) begin
        n_fail++; $display("[TB] FAIL drive_gpio_in0_case%0d: got %b expected 0", k, gpio_in[0]);
      end
    end
    tb_val[0] = 1'b0;
    tb_en[0]  = 1'b1;
    step(1);
  endtask

  task automatic test_sync_latency();
    tb_val[1] = 1'b1;
    step(2);
    n_checks++;
    if (gpio_in[1] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sync_early: got %b expected 0", gpio_in[1]);
    end
    step(1);
    n_checks++;
    if (gpio_in[1] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sync_latency: got %b expected 1", gpio_in[1]);
    end
  endtask

  task automatic test_debounce();
    logic seen;
    int   first;
    r_deb_thr     = 8'd4;
    r_deb_en[2]   = 1'b1;
    r_irq_rise[2] = 1'b1;
    step(2);
    seen      = 1'b0;
    tb_val[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k == 3) tb_val[2] = 1'b0;
      seen = seen | gpio_in[2];
    end
    n_checks++;
    if (seen !== !DEB_BUILT) begin
      n_fail++; $display("[TB] FAIL deb_glitch_seen: got %b expected %b", seen, !DEB_BUILT);
    end
    n_checks++;
    if (irq_pend[2] !== !DEB_BUILT) begin
      n_fail++; $display("[TB] FAIL deb_glitch_pend: got %b expected %b", irq_pend[2], !DEB_BUILT);
    end
    irq_clr[2] = 1'b1;
    step(1);
    irq_clr[2] = 1'b0;
    step(1);

    first     = 0;
    tb_val[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (first == 0 && gpio_in[2] === 1'b1) first = k;
      if (k == 6) tb_val[2] = 1'b0;
    end
    step(2);
    n_checks++;
    if (first != (DEB_BUILT ? 6 : 3)) begin
      n_fail++; $display("[TB] FAIL deb_latency: got %0d edges expected %0d", first, DEB_BUILT ? 6 : 3);
    end
    n_checks++;
    if (irq_pend[2] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL deb_long_pend: got %b expected 1", irq_pend[2]);
    end
    irq_clr[2]    = 1'b1;
    r_irq_rise[2] = 1'b0;
    step(1);
    irq_clr[2] = 1'b0;
  endtask

  task automatic test_interrupts();
    r_irq_fall[3] = 1'b1;
    r_irq_en[3]   = 1'b1;
    tb_val[3]     = 1'b1;
    step(5);
    n_checks++;
    if (irq_pend[3] !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("[TB] FAIL irq_rise_ignored: got pend=%b irq=%b expected 0/0", irq_pend[3], irq);
    end
    tb_val[3] = 1'b0;
    step(3);
    n_checks++;
    if (irq_pend[3] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL irq_pend_early: got %b expected 0", irq_pend[3]);
    end
    step(1);
    n_checks++;
    if (irq_pend[3] !== 1'b1 || irq !== 1'b0) begin
      n_fail++; $display("[TB] FAIL irq_fall_pend: got pend=%b irq=%b expected 1/0", irq_pend[3], irq);
    end
    step(1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("[TB] FAIL irq_registered: got %b expected 1", irq);
    end
    irq_clr[3] = 1'b1;
    step(1);
    irq_clr[3] = 1'b0;
    n_checks++;
    if (irq_pend[3] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL irq_clr_pend: got %b expected 0", irq_pend[3]);
    end
    step(1);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("[TB] FAIL irq_clr_irq: got %b expected 0", irq);
    end
    tb_val[3] = 1'b1;
    step(4);
    tb_val[3] = 1'b0;
    step(4);
    n_checks++;
    if (irq_pend[3] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL irq_second_fall: got %b expected 1", irq_pend[3]);
    end
    tb_val[3] = 1'b1;
    step(4);
    tb_val[3] = 1'b0;
    step(3);
    irq_clr[3] = 1'b1;
    step(1);
    irq_clr[3] = 1'b0;
    n_checks++;
    if (irq_pend[3] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL irq_set_wins: got %b expected 1", irq_pend[3]);
    end
    step(2);
  endtask

  task automatic test_dir_switch();
    r_type[0]     = 1'b1;
    gpio_out[0]   = 1'b1;
    r_dir[0]      = 1'b1;
    tb_val[0]     = 1'b0;
    r_irq_rise[0] = 1'b1;
    r_irq_fall[0] = 1'b1;
    step(4);
    r_dir[0] = 1'b0;
    step(3);
    n_checks++;
    if (gpio_in[0] !== 1'b0 || irq_pend[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dir_low_switch: got in=%b pend=%b expected 0/0", gpio_in[0], irq_pend[0]);
    end
    r_dir[0]  = 1'b1;
    tb_val[0] = 1'b1;
    step(4);
    n_checks++;
    if (gpio_in[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dir_out_masks_in: got %b expected 0", gpio_in[0]);
    end
    r_dir[0] = 1'b0;
    step(3);
    n_checks++;
    if (gpio_in[0] !== 1'b1 || irq_pend[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dir_high_switch: got in=%b pend=%b expected 1/0", gpio_in[0], irq_pend[0]);
    end
    r_irq_rise[0] = 1'b0;
    r_irq_fall[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first;
    n_checks++;
    if (irq_pend[3] !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rstmid_pre: got pend=%b irq=%b expected 1/1", irq_pend[3], irq);
    end
    tb_val[2] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if (irq_pend !== 4'b0000 || irq !== 1'b0 || gpio_in !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL rstmid_clear: got pend=%b irq=%b in=%b expected 0000/0/0000", irq_pend, irq, gpio_in);
    end
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (first == 0 && gpio_in[2] === 1'b1) first = k;
    end
    n_checks++;
    if (first != (DEB_BUILT ? 6 : 3)) begin
      n_fail++; $display("[TB] FAIL rstmid_restart: got %0d edges expected %0d", first, DEB_BUILT ? 6 : 3);
    end
  endtask

  initial begin
    rst        = 1'b1;
    r_type     = '0;
    r_dir      = '0;
    gpio_out   = '0;
    r_deb_en   = '0;
    r_deb_thr  = '0;
    r_irq_en   = '0;
    r_irq_rise = '0;
    r_irq_fall = '0;
    irq_clr    = '0;
    tb_en      = 4'b1111;
    tb_val     = 4'b0000;
    $display("[TB] starting gpio_pad_bank bench, debounce built = %0d", DEB_BUILT);
    test_reset();
    test_drive_modes();
    test_sync_latency();
    test_debounce();
    test_interrupts();
    test_dir_switch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
